// File: rtl/apb_manager.sv
// apb_manager: APB requester turning a command/response handshake into SETUP/ACCESS transfers
// with wait-state support and an optional ACCESS-phase timeout.
module apb_manager #(
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              busy,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t            state_q, state_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   always_comb begin
      state_d       = state_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      cnt_d         = cnt_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            state_d  = SETUP;
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = '0;
         end
         ACCESS: if (pready) begin
            state_d       = RESP;
            rsp_rdata_d   = pwrite_q ? '0 : prdata;
            rsp_err_d     = pslverr;
            rsp_timeout_d = 1'b0;
         end else if (TIMEOUT > 0 && cnt_q == LAST) begin
            state_d       = RESP;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         RESP: state_d = rsp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q       <= IDLE;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         cnt_q         <= cnt_d;
      end
   end

   assign cmd_ready   = state_q == IDLE;
   assign busy        = state_q != IDLE;
   assign psel        = state_q == SETUP || state_q == ACCESS;
   assign penable     = state_q == ACCESS;
   assign rsp_valid   = state_q == RESP;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
endmodule

// File: doc/apb_manager.md
Name: apb_manager

Overview:
- APB requester that drives the UART configuration/status register bank from a simple command handshake; the initiating end of the same APB link used by the UART receiver's subordinate.
- Accepts one command at a time, runs the SETUP/ACCESS phases, tolerates pready wait states, enforces a timeout and returns read data and error status through a response handshake.
- Sits between a controller (CPU stub, testbench driver or init sequencer) and the APB bus.

Parameters:
- ADDR_W, 3, paddr/cmd_addr width
- DATA_W, 8, pwdata/prdata/cmd_wdata/rsp_rdata width
- TIMEOUT, 16, maximum ACCESS cycles without pready before abort; 0 disables the timeout

Ports:
- clk  in  1  clock; all logic on the rising edge
- n_rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target register address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers
- rsp_err  out  1  pslverr sampled, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- busy  out  1  high in any state except IDLE
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  subordinate ready; tie high for zero-wait subordinates
- pslverr  in  1  subordinate error

Behaviour:
- Reset (async): state=IDLE; psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout = 0; paddr, pwdata, rsp_rdata = 0; wait counter = 0. Reset in mid-transfer drops psel/penable immediately and discards the command and any pending response.
- States: IDLE, SETUP, ACCESS, RESP. All outputs decode from registers only (no combinational path from inputs to outputs).
- IDLE: cmd_ready=1. If cmd_valid is high at a clock edge, capture cmd_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
- SETUP, exactly 1 cycle: psel=1, penable=0. Go to ACCESS and clear the wait counter.
- ACCESS: psel=1, penable=1.
  - If pready=1: rsp_rdata = prdata for reads, 0 for writes; rsp_err = pslverr; rsp_timeout = 0; go to RESP.
  - Else if TIMEOUT>0 and counter == TIMEOUT-1: rsp_rdata=0, rsp_err=1, rsp_timeout=1; go to RESP. ACCESS therefore lasts exactly TIMEOUT cycles.
  - Else: counter increments.
  - Counter width = max(1, $clog2(TIMEOUT+1)).
- RESP: psel=0, penable=0, rsp_valid=1. Response fields hold stable until rsp_ready=1 at an edge, then go to IDLE. cmd_ready=0 here, so a new command is accepted no earlier than the cycle after the handshake.
- pwrite, paddr and pwdata hold stable from SETUP through ACCESS and keep their last values in IDLE/RESP. They change only on command capture.
- Latency with pready=1 throughout: command accepted at edge 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3. Each wait state adds 1 cycle. Back-to-back throughput is 1 transfer per 4 cycles.
- pslverr and prdata are sampled only in the ACCESS cycle where pready=1 and ignored otherwise.
- Timeout and pready sampled high in the same cycle: pready wins, so the transfer completes normally.
- Any cmd_valid outside IDLE is ignored, with no capture.

Test Plan:
- Write cmd addr=2, wdata=0x34, pready=1 -> cycle 1: psel=1, penable=0, paddr=2, pwrite=1, pwdata=0x34; cycle 2: penable=1; cycle 3: rsp_valid=1, rsp_err=0, rsp_rdata=0, psel=0.
- Read addr=3 with pready low for 2 ACCESS cycles, prdata=0x5A on the third -> ACCESS lasts 3 cycles, rsp_rdata=0x5A, rsp_err=0, addr/psel held stable throughout.
- Write addr=0 with pslverr=1 and pready=1 -> rsp_err=1, rsp_timeout=0; a following read of addr=4 returning 0x08 -> rsp_err=0, rsp_rdata=0x08.
- TIMEOUT=4, read with pready held 0 -> penable high for exactly 4 cycles, then rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0; also TIMEOUT=0 with pready low for 50 cycles -> no abort.
- rsp_ready low for 3 cycles with cmd_valid held high -> rsp fields stable, cmd_ready=0, no bus activity; after the handshake, IDLE for 1 cycle, then the next SETUP.
- Assert n_rst during ACCESS -> psel, penable, busy = 0 asynchronously; after release, IDLE with cmd_ready=1 and no stale rsp_valid.
